// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register target: FSM states, bus levels,
// and the position of the R/W flag in the address byte.
package i2c_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_PTR,
      ST_PTR_ACK,
      ST_WDATA,
      ST_WDATA_ACK,
      ST_RDATA,
      ST_RDATA_ACK,
      ST_IGNORE
   } i2c_state_e;

   localparam logic ACK_LVL  = 1'b0;
   localparam logic NACK_LVL = 1'b1;
   localparam int   RW_BIT   = 0;

endpackage

// File: rtl/i2c_target_if.sv
// Register-file side of the I2C target: write strobe plus read address/data.
// master = the I2C target (drives writes and read address),
// slave  = the register file (returns read data).
interface i2c_target_if #(parameter int PTR_W = 8);

   logic             wr_valid;
   logic [PTR_W-1:0] wr_addr;
   logic [7:0]       wr_data;
   logic [PTR_W-1:0] rd_addr;
   logic [7:0]       rd_data;

   modport master (output wr_valid, wr_addr, wr_data, rd_addr, input rd_data);
   modport slave  (input wr_valid, wr_addr, wr_data, rd_addr, output rd_data);

endinterface

// File: rtl/i2c_line_sync.sv
// One I2C pad line: 2-flop synchronizer, optional 3-sample majority filter
// (enabled by defining I2C_TARGET_GLITCH_FILTER_EN), and rise/fall pulses.
// All flops reset to 1 so an idle bus produces no spurious edges.
module i2c_line_sync (
   input  logic clk,
   input  logic rst,
   input  logic i_line,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [1:0] r_sync;
   logic       r_prev;
   logic       w_clean;

   // bring the asynchronous pad into the clk domain
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_sync <= 2'b11;
      else     r_sync <= {r_sync[0], i_line};
   end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
   logic [2:0] r_hist;
   logic       r_filt;

   // majority of the last three samples; a single-clk pulse never wins
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hist <= 3'b111;
         r_filt <= 1'b1;
      end else begin
         r_hist <= {r_hist[1:0], r_sync[1]};
         r_filt <= (r_hist[0] & r_hist[1]) | (r_hist[0] & r_hist[2]) |
                   (r_hist[1] & r_hist[2]);
      end
   end

   assign w_clean = r_filt;
`else
   assign w_clean = r_sync[1];
`endif

   // previous clean level for edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_prev <= 1'b1;
      else     r_prev <= w_clean;
   end

   assign o_level = w_clean;
   assign o_rise  = w_clean & ~r_prev;
   assign o_fall  = ~w_clean & r_prev;

endmodule

// File: rtl/i2c_target.sv
// I2C register target: 7-bit address, pointer byte, auto-incrementing
// burst reads and writes. Optional SCL/SDA glitch filter via
// I2C_TARGET_GLITCH_FILTER_EN (see i2c_line_sync).
module i2c_target
   import i2c_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR = 7'h10,
   parameter int         PTR_W    = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         scl_in,
   input  logic         sda_in,
   output logic         sda_oe,
   output logic         busy,
   i2c_target_if.master bus
);

   logic w_scl, w_scl_rise, w_scl_fall;
   logic w_sda, w_sda_rise, w_sda_fall;
   logic w_start, w_stop;
   logic [7:0] w_byte_in;

   i2c_state_e       r_state;
   logic [3:0]       r_bitcnt;
   logic [7:0]       r_shift;
   logic [PTR_W-1:0] r_ptr;
   logic             r_rw;
   logic             r_sda_oe;
   logic             r_busy;
   logic             r_wr_valid;
   logic [PTR_W-1:0] r_wr_addr;
   logic [7:0]       r_wr_data;
   logic [PTR_W-1:0] r_rd_addr;

   i2c_line_sync u_scl (.clk(clk), .rst(rst), .i_line(scl_in),
                        .o_level(w_scl), .o_rise(w_scl_rise), .o_fall(w_scl_fall));
   i2c_line_sync u_sda (.clk(clk), .rst(rst), .i_line(sda_in),
                        .o_level(w_sda), .o_rise(w_sda_rise), .o_fall(w_sda_fall));

   assign w_start   = w_sda_fall & w_scl;
   assign w_stop    = w_sda_rise & w_scl;
   assign w_byte_in = {r_shift[6:0], w_sda};

   // protocol FSM: START/STOP take priority over SCL edges; bits are sampled
   // on SCL rise, SDA drive only changes on SCL fall
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_bitcnt   <= '0;
         r_shift    <= '0;
         r_ptr      <= '0;
         r_rw       <= 1'b0;
         r_sda_oe   <= 1'b0;
         r_busy     <= 1'b0;
         r_wr_valid <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
         r_rd_addr  <= '0;
      end else begin
         r_wr_valid <= 1'b0;
         if (w_stop) begin
            r_state  <= ST_IDLE;
            r_sda_oe <= 1'b0;
            r_busy   <= 1'b0;
         end else if (w_start) begin
            r_state  <= ST_ADDR;
            r_bitcnt <= '0;
         end else if (w_scl_rise) begin
            case (r_state)
               ST_ADDR, ST_PTR, ST_WDATA: begin
                  if (r_bitcnt != 4'd8) begin
                     r_shift  <= w_byte_in;
                     r_bitcnt <= r_bitcnt + 1'b1;
                     if (r_state == ST_WDATA && r_bitcnt == 4'd7) begin
                        r_wr_valid <= 1'b1;
                        r_wr_addr  <= r_ptr;
                        r_wr_data  <= w_byte_in;
                        r_ptr      <= r_ptr + 1'b1;
                     end
                  end
               end
               // the byte just sent is consumed whether ACKed or not
               ST_RDATA_ACK: begin
                  r_ptr     <= r_ptr + 1'b1;
                  r_rd_addr <= r_ptr + 1'b1;
                  if (w_sda == NACK_LVL) r_state <= ST_IGNORE;
               end
               default: ;
            endcase
         end else if (w_scl_fall) begin
            case (r_state)
               ST_ADDR: begin
                  if (r_bitcnt == 4'd8) begin
                     if (r_shift[7:1] == DEV_ADDR) begin
                        r_sda_oe  <= 1'b1;
                        r_busy    <= 1'b1;
                        r_rw      <= r_shift[RW_BIT];
                        r_rd_addr <= r_ptr;
                        r_state   <= ST_ADDR_ACK;
                     end else begin
                        r_state <= ST_IGNORE;
                     end
                  end
               end
               ST_ADDR_ACK, ST_RDATA_ACK: begin
                  // ACKed read (or read address phase): present next byte MSB
                  if (r_state == ST_RDATA_ACK || r_rw) begin
                     r_sda_oe <= ~bus.rd_data[7];
                     r_shift  <= {bus.rd_data[6:0], 1'b0};
                     r_bitcnt <= 4'd1;
                     r_state  <= ST_RDATA;
                  end else begin
                     r_sda_oe <= 1'b0;
                     r_bitcnt <= '0;
                     r_state  <= ST_PTR;
                  end
               end
               ST_PTR: begin
                  if (r_bitcnt == 4'd8) begin
                     r_ptr    <= PTR_W'(r_shift);
                     r_sda_oe <= 1'b1;
                     r_state  <= ST_PTR_ACK;
                  end
               end
               ST_WDATA: begin
                  if (r_bitcnt == 4'd8) begin
                     r_sda_oe <= 1'b1;
                     r_state  <= ST_WDATA_ACK;
                  end
               end
               ST_PTR_ACK, ST_WDATA_ACK: begin
                  r_sda_oe <= 1'b0;
                  r_bitcnt <= '0;
                  r_state  <= ST_WDATA;
               end
               ST_RDATA: begin
                  if (r_bitcnt == 4'd8) begin
                     r_sda_oe <= 1'b0;
                     r_state  <= ST_RDATA_ACK;
                  end else begin
                     r_sda_oe <= ~r_shift[7];
                     r_shift  <= {r_shift[6:0], 1'b0};
                     r_bitcnt <= r_bitcnt + 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign sda_oe       = r_sda_oe;
   assign busy         = r_busy;
   assign bus.wr_valid = r_wr_valid;
   assign bus.wr_addr  = r_wr_addr;
   assign bus.wr_data  = r_wr_data;
   assign bus.rd_addr  = r_rd_addr;

endmodule
